// File: rtl/line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_pkg
//   Shared definitions for the double-banked RGB565 scanline buffer:
//   RGB565 field widths and pixel struct, default fill colour, write-side
//   FSM state codes, line-event codes and output-select codes.
//   No ports (package).
// -----------------------------------------------------------------------------
package line_buffer_pkg;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int PIX_W = R_W + G_W + B_W;

  localparam logic [PIX_W-1:0] FILL_COLOR_DEF = 16'h0000;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // Write-side FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // Line events seen this cycle (at most one is reported)
  localparam logic [1:0] EV_NONE  = 2'd0;
  localparam logic [1:0] EV_FRAME = 2'd1;
  localparam logic [1:0] EV_FIRST = 2'd2;
  localparam logic [1:0] EV_LINE  = 2'd3;

  // What the registered pixel output shows
  localparam logic [1:0] OUT_ZERO = 2'd0;
  localparam logic [1:0] OUT_FILL = 2'd1;
  localparam logic [1:0] OUT_RAM  = 2'd2;

  function automatic rgb565_t to_rgb(input logic [PIX_W-1:0] pix);
    return rgb565_t'(pix);
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// -----------------------------------------------------------------------------
// line_buffer_ram
//   Simple dual-port pixel RAM holding both scanline banks. The address MSB
//   selects the bank, the low AW bits the pixel index. One synchronous write
//   port and one registered read port (1-cycle read latency).
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   {bank, index} write address
//   wdata  in   RGB565 write data
//   raddr  in   {bank, index} read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module line_buffer_ram
  import line_buffer_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW:0]      waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW:0]      raddr,
  output logic [PIX_W-1:0] rdata
);

  // Bank select on the MSB keeps address decode trivial; indices at or above
  // the line width are never written and are masked by the caller on read.
  logic [PIX_W-1:0] mem [0:(2**(AW+1))-1];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
//   Double-banked RGB565 scanline buffer in front of the LCD driver. The
//   renderer fills the write bank through wr_valid/wr_ready while the LCD
//   reads the read bank by hpos; the banks swap at each line boundary.
//   Pixels not written before a swap read as FILL_COLOR, and a short fill
//   sets the sticky underrun flag (cleared at the next frame start).
// Ports:
//   cin, reset            clock; synchronous active-high reset
//   hpos, vpos            current display position from the LCD driver
//   hsync, vsync          LCD timing (hsync high while hpos==0)
//   red, green, blue      registered displayed pixel
//   line_start, line_num  render request pulse and the line to render
//   wr_valid, wr_data     renderer pixel stream
//   wr_ready              beat accepted when wr_valid & wr_ready
//   underrun              sticky short-fill flag
// -----------------------------------------------------------------------------
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int               WIDTH      = 320,
  parameter int               HEIGHT     = 240,
  parameter logic [PIX_W-1:0] FILL_COLOR = FILL_COLOR_DEF
) (
  input  logic                      cin,
  input  logic                      reset,
  input  logic [$clog2(WIDTH)-1:0]  hpos,
  input  logic [$clog2(HEIGHT)-1:0] vpos,
  input  logic                      hsync,
  input  logic                      vsync,
  output logic [4:0]                red,
  output logic [5:0]                green,
  output logic [4:0]                blue,
  output logic                      line_start,
  output logic [$clog2(HEIGHT)-1:0] line_num,
  input  logic                      wr_valid,
  input  logic [15:0]               wr_data,
  output logic                      wr_ready,
  output logic                      underrun
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = $clog2(HEIGHT);

  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic [1:0]    state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic          underrun_q, underrun_d;
  logic          line_start_q, line_start_d;
  logic [HW-1:0] line_num_q, line_num_d;
  logic [1:0]    out_sel_q, out_sel_d;

  logic [1:0]       ev;
  logic             wr_fire;
  logic             req;
  logic [HW-1:0]    req_line;
  logic [HW:0]      vpos_inc;
  logic [PIX_W-1:0] ram_rdata;
  rgb565_t          pix_out;

  // FRAME needs vsync high and LINE needs vsync low, so FRAME always wins a
  // same-cycle hsync rise. FIRST is given priority over a coincident LINE so
  // only one swap happens.
  always_comb begin
    ev = EV_NONE;
    if (vsync && !vsync_q)                   ev = EV_FRAME;
    else if (!vsync && vsync_q)              ev = EV_FIRST;
    else if (hsync && !hsync_q && !vsync)    ev = EV_LINE;
  end

  // Dropping ready on the event cycle guarantees the swap cycle carries no
  // write, so a beat is never split across banks.
  assign wr_ready = (state_q == ST_FILL) && (ev == EV_NONE) && !reset;
  assign wr_fire  = wr_valid && wr_ready;
  assign vpos_inc = {1'b0, vpos} + (HW+1)'(1);

  always_comb begin
    vsync_d      = vsync;
    hsync_d      = hsync;
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    underrun_d   = underrun_q;
    line_start_d = 1'b0;
    line_num_d   = line_num_q;
    req          = 1'b0;
    req_line     = '0;

    case (ev)
      EV_FRAME: begin
        // Abort any fill; nothing is swapped, so no underrun is flagged.
        wr_count_d = '0;
        underrun_d = 1'b0;
        req        = 1'b1;
        req_line   = '0;
      end
      EV_FIRST, EV_LINE: begin
        rd_bank_d  = ~rd_bank_q;
        rd_count_d = wr_count_q;
        wr_count_d = '0;
        if (wr_count_q < CW'(WIDTH)) underrun_d = 1'b1;
        if (ev == EV_FIRST) begin
          req      = (HEIGHT > 1);
          req_line = HW'(1);
        end else begin
          req      = (vpos_inc < (HW+1)'(HEIGHT));
          req_line = vpos_inc[HW-1:0];
        end
      end
      default: begin
        if (wr_fire && (wr_count_q < CW'(WIDTH))) wr_count_d = wr_count_q + CW'(1);
      end
    endcase

    if (ev != EV_NONE) begin
      state_d = req ? ST_FILL : ST_IDLE;
      if (req) begin
        line_start_d = 1'b1;
        line_num_d   = req_line;
      end
    end else if ((state_q == ST_FILL) && wr_fire && (wr_count_q == CW'(WIDTH - 1))) begin
      state_d = ST_FULL;
    end

    // rd_count never exceeds WIDTH, so this also masks hpos beyond the line.
    out_sel_d = (CW'(hpos) < rd_count_q) ? OUT_RAM : OUT_FILL;
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      vsync_q      <= vsync;
      hsync_q      <= hsync;
      state_q      <= ST_IDLE;
      rd_bank_q    <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      underrun_q   <= 1'b0;
      line_start_q <= 1'b0;
      line_num_q   <= '0;
      out_sel_q    <= OUT_ZERO;
    end else begin
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      underrun_q   <= underrun_d;
      line_start_q <= line_start_d;
      line_num_q   <= line_num_d;
      out_sel_q    <= out_sel_d;
    end
  end

  line_buffer_ram #(.AW(AW)) u_ram (
    .clk   (cin),
    .we    (wr_fire),
    .waddr ({~rd_bank_q, wr_count_q[AW-1:0]}),
    .wdata (wr_data),
    .raddr ({rd_bank_q, hpos}),
    .rdata (ram_rdata)
  );

  // The select travels one cycle alongside the registered RAM read.
  always_comb begin
    case (out_sel_q)
      OUT_RAM:  pix_out = to_rgb(ram_rdata);
      OUT_FILL: pix_out = to_rgb(FILL_COLOR);
      default:  pix_out = '0;
    endcase
  end

  assign red        = pix_out.r;
  assign green      = pix_out.g;
  assign blue       = pix_out.b;
  assign line_start = line_start_q;
  assign line_num   = line_num_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_buffer
//   Randomised scoreboard bench for line_buffer. The driver applies one cycle
//   of stimulus, steps a queue-based line model and pushes the expected
//   responses; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_line_buffer;

  localparam int          WIDTH  = 320;
  localparam int          HEIGHT = 240;
  localparam logic [15:0] FILL   = 16'hF81F;
  localparam int          AW     = $clog2(WIDTH);
  localparam int          HW     = $clog2(HEIGHT);

  logic          cin = 1'b0;
  logic          reset, hsync, vsync, wr_valid;
  logic [AW-1:0] hpos;
  logic [HW-1:0] vpos;
  logic [15:0]   wr_data;
  logic [4:0]    red, blue;
  logic [5:0]    green;
  logic          line_start, wr_ready, underrun;
  logic [HW-1:0] line_num;

  line_buffer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .FILL_COLOR(FILL)) dut (
    .cin(cin), .reset(reset), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .line_start(line_start), .line_num(line_num),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .underrun(underrun)
  );

  always #5 cin = ~cin;

  typedef struct { int due; int rdy; } now_t;
  typedef struct { int due; int pix; int und; int ls; int lnum; } nxt_t;

  now_t q_now[$];
  nxt_t q_nxt[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the line being rendered and the line being shown.
  logic [15:0] wbuf[$];
  logic [15:0] rbuf[$];
  bit          m_act, m_und, m_pvs, m_phs;
  int          m_lnum;

  always @(posedge cin) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  now_t mn;
  nxt_t mx;
  always @(negedge cin) begin
    while (q_now.size() > 0 && q_now[0].due == cyc) begin
      mn = q_now.pop_front();
      chk("wr_ready", 32'(wr_ready), mn.rdy);
    end
    while (q_nxt.size() > 0 && q_nxt[0].due == cyc) begin
      mx = q_nxt.pop_front();
      chk("rgb", {16'h0, red, green, blue}, mx.pix);
      chk("underrun", 32'(underrun), mx.und);
      chk("line_start", 32'(line_start), mx.ls);
      chk("line_num", 32'(line_num), mx.lnum);
    end
  end

  task automatic model(input logic r, vs, hs, input int vp, hp, input logic wv, input logic [15:0] wd);
    bit frame, first, line, ev, rdy, ls;
    int pix, nxt;
    if (r) begin
      wbuf.delete(); rbuf.delete();
      m_act = 0; m_und = 0; m_lnum = 0; m_pvs = vs; m_phs = hs;
      q_nxt.push_back('{cyc + 1, 0, 0, 0, 0});
      return;
    end
    frame = vs && !m_pvs;
    first = !vs && m_pvs;
    line  = hs && !m_phs && !vs;
    ev    = frame || first || line;
    rdy   = m_act && (wbuf.size() < WIDTH) && !ev;
    q_now.push_back('{cyc, int'(rdy)});
    pix = (hp < rbuf.size()) ? int'(rbuf[hp]) : int'(FILL);
    ls  = 0;
    if (frame) begin
      wbuf.delete(); m_und = 0; m_act = 1; ls = 1; m_lnum = 0;
    end else if (first || line) begin
      if (wbuf.size() < WIDTH) m_und = 1;
      rbuf = wbuf;
      wbuf.delete();
      nxt = first ? 1 : vp + 1;
      if (nxt < HEIGHT) begin m_act = 1; ls = 1; m_lnum = nxt; end
      else m_act = 0;
    end else if (rdy && wv) begin
      wbuf.push_back(wd);
    end
    q_nxt.push_back('{cyc + 1, pix, int'(m_und), int'(ls), m_lnum});
    m_pvs = vs; m_phs = hs;
  endtask

  task automatic step(input logic r, vs, hs, input int vp, hp, input logic wv, input logic [15:0] wd);
    @(posedge cin); #1;
    reset = r; vsync = vs; hsync = hs; vpos = HW'(vp); hpos = AW'(hp);
    wr_valid = wv; wr_data = wd;
    model(r, vs, hs, vp, hp, wv, wd);
  endtask

  // wmode 1 holds wr_valid high every cycle; otherwise valid is random and
  // stops once max_beats are in the model's write line. dmode 1 sends index data.
  function automatic logic [15:0] pick_data(input int dmode);
    return dmode ? 16'(wbuf.size()) : 16'($urandom);
  endfunction

  function automatic logic pick_valid(input int wmode, input int max_beats);
    if (wmode == 1) return 1'b1;
    return (wbuf.size() < max_beats) && ($urandom_range(0, 3) != 0);
  endfunction

  task automatic do_line(input int vp, len, max_beats, wmode, hmode, dmode);
    for (int i = 0; i < len; i++) begin
      int hp;
      hp = (hmode != 0 && i != 0) ? int'($urandom_range(0, (1 << AW) - 1)) : i % (1 << AW);
      step(0, 0, (i == 0), vp, hp, pick_valid(wmode, max_beats), pick_data(dmode));
    end
  endtask

  task automatic do_frame(input int vs_len, gap, wmode, dmode, input bit hs_first);
    for (int i = 0; i < vs_len; i++)
      step(0, 1, hs_first && (i == 0), 0, i % (1 << AW), pick_valid(wmode, WIDTH), pick_data(dmode));
    for (int i = 0; i < gap; i++)
      step(0, 0, 0, 0, i, pick_valid(wmode, WIDTH), pick_data(dmode));
  endtask

  initial begin
    reset = 1; vsync = 0; hsync = 0; vpos = '0; hpos = '0; wr_valid = 0; wr_data = '0;

    repeat (3) step(1, 0, 0, 0, 0, 0, 16'h0);

    // Partial fill, then reset mid-FILL with wr_valid held high.
    do_frame(60, 0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 3, 1, 16'h1234);
    repeat (5) step(0, 0, 0, 0, $urandom_range(0, 400), 1, 16'h0055);

    // Full index-valued fill during vsync; FIRST brings it to the read side.
    do_frame(400, 30, 1, 1, 0);
    do_line(1, 440, WIDTH, 0, 0, 0);

    // Short fill of 100 beats after LINE at vpos 7.
    do_line(7, 440, 100, 0, 0, 1);
    do_line(8, 440, WIDTH, 0, 0, 0);

    // wr_valid held high across line edges.
    do_line(20, 440, WIDTH, 1, 0, 1);
    do_line(21, 440, WIDTH, 1, 1, 0);
    do_line(22, 440, WIDTH, 1, 0, 1);

    // Last line of the frame: no request, then FRAME with coincident hsync.
    do_line(238, 440, WIDTH, 0, 0, 1);
    do_line(239, 440, WIDTH, 1, 0, 0);
    do_line(239, 40, WIDTH, 1, 1, 0);
    do_frame(400, 30, 0, 0, 1);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_frame($urandom_range(20, 400), 10, $urandom_range(0, 1), $urandom_range(0, 1),
                 1'($urandom_range(0, 1)));
      do_line($urandom_range(0, HEIGHT - 1), $urandom_range(340, 440), $urandom_range(0, WIDTH),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    repeat (3) @(negedge cin);
    #1;
    chk("sb_drain", q_now.size() + q_nxt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
